// File: rtl/apb_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_i2c_pkg
// Description : Shared definitions for the APB I2C master controller:
//               register offsets, CTRL/STATUS bit positions, the sequencer
//               state encoding and command-entry field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_i2c_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [4:0] c_OFS_CTRL   = 5'h00;
    localparam logic [4:0] c_OFS_WDATA  = 5'h04;
    localparam logic [4:0] c_OFS_CMD    = 5'h08;
    localparam logic [4:0] c_OFS_STATUS = 5'h0C;
    localparam logic [4:0] c_OFS_RDATA  = 5'h10;

    // CTRL bits
    localparam int c_CTRL_EN     = 0;
    localparam int c_CTRL_IRQ_EN = 1;
    localparam int c_CTRL_HALT   = 2;
    localparam int c_CTRL_FLUSH  = 3;

    // STATUS bits; [11:8] are sticky, write-1-to-clear
    localparam int c_ST_BUSY      = 0;
    localparam int c_ST_CMD_EMPTY = 1;
    localparam int c_ST_CMD_FULL  = 2;
    localparam int c_ST_RD_EMPTY  = 3;
    localparam int c_ST_RD_FULL   = 4;
    localparam int c_ST_NACK      = 8;
    localparam int c_ST_CMD_OVF   = 9;
    localparam int c_ST_RD_OVF    = 10;
    localparam int c_ST_RD_UNF    = 11;

    // CMD register fields
    localparam int c_CMD_RH_WL    = 31;
    localparam int c_CMD_BIT_CTRL = 30;

    // Command entry = {rh_wl, bit_ctrl, addr[15:0], wdata}
    localparam int c_I2C_ADDR_W = 16;
    localparam int c_CMD_HDR_W  = 2 + c_I2C_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } i2c_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with flush.
//               Ports: clk, rst_n (sync, active-low), i_push/i_wdata,
//               i_pop, i_flush, o_rdata (head), o_full, o_empty.
//               A push into a full FIFO is accepted only when a pop frees
//               the slot in the same cycle; flush overrides push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    // Extra pointer MSB distinguishes full from empty
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the empty flag guards every read of it
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && w_do_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/apb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_i2c_master_ctrl
// Description : APB3 slave that queues I2C commands and sequences them into
//               the I2C master core.
//               APB side : i_apb_psel/penable/pwrite/paddr/pwdata in,
//                          o_apb_prdata/pready/pslverr out, o_irq out.
//               Core side: m_i2c_wvalid/bit_ctrl/rh_wl/addr/wdata out,
//                          m_i2c_wready/rdata/rvalid/done/ack in.
//               Clock apb_clk, reset apb_rstn (synchronous, active-low).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_i2c_master_ctrl
    import apb_i2c_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
    parameter int          APB_ABIT  = 32,
    parameter int          CMD_DEPTH = 4,
    parameter int          RD_DEPTH  = 4,
    parameter int          WR_BITS   = 1,
    parameter int          RD_BITS   = 1
) (
    input  logic                  apb_clk,
    input  logic                  apb_rstn,
    input  logic                  i_apb_psel,
    input  logic                  i_apb_penable,
    input  logic                  i_apb_pwrite,
    input  logic [APB_ABIT-1:0]   i_apb_paddr,
    input  logic [31:0]           i_apb_pwdata,
    output logic [31:0]           o_apb_prdata,
    output logic                  o_apb_pready,
    output logic                  o_apb_pslverr,
    output logic                  o_irq,
    output logic                  m_i2c_wvalid,
    input  logic                  m_i2c_wready,
    output logic                  m_i2c_bit_ctrl,
    output logic                  m_i2c_rh_wl,
    output logic [15:0]           m_i2c_addr,
    output logic [WR_BITS*8-1:0]  m_i2c_wdata,
    input  logic [RD_BITS*8-1:0]  m_i2c_rdata,
    input  logic                  m_i2c_rvalid,
    input  logic                  m_i2c_done,
    input  logic                  m_i2c_ack
);
    localparam int c_WR_W  = WR_BITS * 8;
    localparam int c_RD_W  = RD_BITS * 8;
    localparam int c_CMD_W = c_CMD_HDR_W + c_WR_W;

    // ---------------- APB decode ----------------
    logic [APB_ABIT-1:0] w_offset;
    logic [4:0]          w_ofs;
    logic                w_acc, w_wr, w_in_range, w_mapped;
    logic                w_wr_ctrl, w_wr_wdata, w_wr_cmd, w_wr_status, w_rd_rdata;

    assign w_acc       = i_apb_psel & i_apb_penable;
    assign w_wr        = w_acc & i_apb_pwrite;
    assign w_offset    = i_apb_paddr - APB_ABIT'(BASE_ADDR);
    assign w_in_range  = (w_offset[APB_ABIT-1:5] == '0);
    assign w_ofs       = w_offset[4:0];
    assign w_mapped    = w_in_range &&
                         (w_ofs == c_OFS_CTRL   || w_ofs == c_OFS_WDATA ||
                          w_ofs == c_OFS_CMD    || w_ofs == c_OFS_STATUS ||
                          w_ofs == c_OFS_RDATA);
    assign w_wr_ctrl   = w_wr & w_in_range & (w_ofs == c_OFS_CTRL);
    assign w_wr_wdata  = w_wr & w_in_range & (w_ofs == c_OFS_WDATA);
    assign w_wr_cmd    = w_wr & w_in_range & (w_ofs == c_OFS_CMD);
    assign w_wr_status = w_wr & w_in_range & (w_ofs == c_OFS_STATUS);
    assign w_rd_rdata  = w_acc & ~i_apb_pwrite & w_in_range & (w_ofs == c_OFS_RDATA);

    assign o_apb_pready  = 1'b1;
    assign o_apb_pslverr = w_acc & ~w_mapped;

    // ---------------- Registers ----------------
    logic              r_en, r_irq_en, r_halt;
    logic [c_WR_W-1:0] r_wdata;
    logic              r_nack, r_cmd_ovf, r_rd_ovf, r_rd_unf;
    logic              w_flush;
    logic [3:0]        w_w1c;
    i2c_state_e        r_state, w_state_nxt;

    assign w_flush = w_wr_ctrl & i_apb_pwdata[c_CTRL_FLUSH];
    assign w_w1c   = w_wr_status ? i_apb_pwdata[c_ST_RD_UNF:c_ST_NACK] : 4'b0;

    // ---------------- FIFOs ----------------
    logic               w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
    logic [c_CMD_W-1:0] w_cmd_din, w_cmd_head;
    logic               w_rd_push, w_rd_pop, w_rd_full, w_rd_empty;
    logic [c_RD_W-1:0]  w_rd_head;

    assign w_cmd_push = w_wr_cmd;
    assign w_cmd_din  = {i_apb_pwdata[c_CMD_RH_WL], i_apb_pwdata[c_CMD_BIT_CTRL],
                         i_apb_pwdata[c_I2C_ADDR_W-1:0], r_wdata};
    // Core responses count only while a transaction is outstanding, so
    // stray pulses after a reset are ignored
    assign w_rd_push  = m_i2c_rvalid & (r_state == S_WAIT);
    assign w_rd_pop   = w_rd_rdata & ~w_rd_empty;

    i2c_sync_fifo #(.WIDTH(c_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(apb_clk), .rst_n(apb_rstn), .i_push(w_cmd_push), .i_pop(w_cmd_pop),
        .i_flush(w_flush), .i_wdata(w_cmd_din), .o_rdata(w_cmd_head),
        .o_full(w_cmd_full), .o_empty(w_cmd_empty)
    );

    i2c_sync_fifo #(.WIDTH(c_RD_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk(apb_clk), .rst_n(apb_rstn), .i_push(w_rd_push), .i_pop(w_rd_pop),
        .i_flush(w_flush), .i_wdata(m_i2c_rdata), .o_rdata(w_rd_head),
        .o_full(w_rd_full), .o_empty(w_rd_empty)
    );

    // Overflow only when no same-cycle pop frees a slot; flush discards the push
    logic w_set_nack, w_set_cmd_ovf, w_set_rd_ovf, w_set_rd_unf;
    assign w_set_nack    = m_i2c_done & m_i2c_ack & (r_state == S_WAIT);
    assign w_set_cmd_ovf = w_cmd_push & w_cmd_full & ~w_cmd_pop & ~w_flush;
    assign w_set_rd_ovf  = w_rd_push & w_rd_full & ~w_rd_pop & ~w_flush;
    assign w_set_rd_unf  = w_rd_rdata & w_rd_empty;

    always_ff @(posedge apb_clk) begin
        if (!apb_rstn) begin
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_halt    <= 1'b0;
            r_wdata   <= '0;
            r_nack    <= 1'b0;
            r_cmd_ovf <= 1'b0;
            r_rd_ovf  <= 1'b0;
            r_rd_unf  <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= i_apb_pwdata[c_CTRL_EN];
                r_irq_en <= i_apb_pwdata[c_CTRL_IRQ_EN];
                r_halt   <= i_apb_pwdata[c_CTRL_HALT];
            end
            if (w_wr_wdata) r_wdata <= i_apb_pwdata[c_WR_W-1:0];
            // Hardware set beats a simultaneous write-1-to-clear
            r_nack    <= w_set_nack    | (r_nack    & ~w_w1c[0]);
            r_cmd_ovf <= w_set_cmd_ovf | (r_cmd_ovf & ~w_w1c[1]);
            r_rd_ovf  <= w_set_rd_ovf  | (r_rd_ovf  & ~w_w1c[2]);
            r_rd_unf  <= w_set_rd_unf  | (r_rd_unf  & ~w_w1c[3]);
        end
    end

    // ---------------- Sequencer ----------------
    always_ff @(posedge apb_clk) begin
        if (!apb_rstn) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_en && !w_cmd_empty && !(r_halt && r_nack)) begin
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: if (m_i2c_wready) w_state_nxt = S_WAIT;
            S_WAIT:  if (m_i2c_done)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command fields are captured on the pop and held through ISSUE/WAIT
    always_ff @(posedge apb_clk) begin
        if (!apb_rstn) begin
            m_i2c_rh_wl    <= 1'b0;
            m_i2c_bit_ctrl <= 1'b0;
            m_i2c_addr     <= '0;
            m_i2c_wdata    <= '0;
        end else if (w_cmd_pop) begin
            {m_i2c_rh_wl, m_i2c_bit_ctrl, m_i2c_addr, m_i2c_wdata} <= w_cmd_head;
        end
    end

    assign m_i2c_wvalid = (r_state == S_ISSUE);
    assign o_irq = r_irq_en & (~w_rd_empty | r_nack | r_cmd_ovf | r_rd_ovf);

    // ---------------- Read mux ----------------
    logic [31:0] w_status;
    always_comb begin
        w_status                 = '0;
        w_status[c_ST_BUSY]      = (r_state != S_IDLE);
        w_status[c_ST_CMD_EMPTY] = w_cmd_empty;
        w_status[c_ST_CMD_FULL]  = w_cmd_full;
        w_status[c_ST_RD_EMPTY]  = w_rd_empty;
        w_status[c_ST_RD_FULL]   = w_rd_full;
        w_status[c_ST_NACK]      = r_nack;
        w_status[c_ST_CMD_OVF]   = r_cmd_ovf;
        w_status[c_ST_RD_OVF]    = r_rd_ovf;
        w_status[c_ST_RD_UNF]    = r_rd_unf;
    end

    always_comb begin
        o_apb_prdata = '0;
        if (w_acc && w_in_range) begin
            case (w_ofs)
                c_OFS_CTRL:   o_apb_prdata[2:0] = {r_halt, r_irq_en, r_en};
                c_OFS_WDATA:  o_apb_prdata[c_WR_W-1:0] = r_wdata;
                c_OFS_STATUS: o_apb_prdata = w_status;
                c_OFS_RDATA:  if (!w_rd_empty) o_apb_prdata[c_RD_W-1:0] = w_rd_head;
                default:      o_apb_prdata = '0;
            endcase
        end
    end

    // Most write-data bits are don't-care for any given register
    logic w_unused;
    assign w_unused = &{1'b0, i_apb_pwdata};

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_master_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_apb_i2c_master_ctrl
// Description : Self-checking bench for apb_i2c_master_ctrl: directed
//               scenarios plus randomized rounds scored against a queue-based
//               reference model of the register/FIFO behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_i2c_master_ctrl;
    localparam logic [31:0] BASE = 32'h43C0_0000;
    localparam int CMD_DEPTH = 4;
    localparam int RD_DEPTH  = 4;
    localparam int WR_W = 8;
    localparam int RD_W = 8;
    localparam int FW   = 18 + WR_W;
    localparam logic [31:0] A_CTRL = BASE + 32'h00, A_WDATA = BASE + 32'h04,
                            A_CMD  = BASE + 32'h08, A_STAT  = BASE + 32'h0C,
                            A_RDAT = BASE + 32'h10;

    logic apb_clk = 1'b0, apb_rstn = 1'b0;
    logic psel = 0, penable = 0, pwrite = 0;
    logic [31:0] paddr = 0, pwdata = 0, prdata;
    logic pready, pslverr, irq;
    logic wvalid, wready = 0, bit_ctrl, rh_wl, rvalid = 0, done = 0, ack = 0;
    logic [15:0] addr;
    logic [WR_W-1:0] wdata;
    logic [RD_W-1:0] rdata = 0;

    always #5 apb_clk = ~apb_clk;

    apb_i2c_master_ctrl #(
        .BASE_ADDR(BASE), .APB_ABIT(32), .CMD_DEPTH(CMD_DEPTH),
        .RD_DEPTH(RD_DEPTH), .WR_BITS(1), .RD_BITS(1)
    ) dut (
        .apb_clk(apb_clk), .apb_rstn(apb_rstn),
        .i_apb_psel(psel), .i_apb_penable(penable), .i_apb_pwrite(pwrite),
        .i_apb_paddr(paddr), .i_apb_pwdata(pwdata), .o_apb_prdata(prdata),
        .o_apb_pready(pready), .o_apb_pslverr(pslverr), .o_irq(irq),
        .m_i2c_wvalid(wvalid), .m_i2c_wready(wready), .m_i2c_bit_ctrl(bit_ctrl),
        .m_i2c_rh_wl(rh_wl), .m_i2c_addr(addr), .m_i2c_wdata(wdata),
        .m_i2c_rdata(rdata), .m_i2c_rvalid(rvalid), .m_i2c_done(done),
        .m_i2c_ack(ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO contents as queues plus the sticky flags
    logic [FW-1:0]   m_cmd_q[$];
    logic [RD_W-1:0] m_rd_q[$];
    logic m_nack, m_cmd_ovf, m_rd_ovf, m_rd_unf, m_irq_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[1]  = (m_cmd_q.size() == 0);
        s[2]  = (m_cmd_q.size() == CMD_DEPTH);
        s[3]  = (m_rd_q.size() == 0);
        s[4]  = (m_rd_q.size() == RD_DEPTH);
        s[8]  = m_nack;
        s[9]  = m_cmd_ovf;
        s[10] = m_rd_ovf;
        s[11] = m_rd_unf;
        return s;
    endfunction

    function automatic logic exp_irq();
        return m_irq_en & ((m_rd_q.size() != 0) | m_nack | m_cmd_ovf | m_rd_ovf);
    endfunction

    task automatic model_clear();
        m_cmd_q.delete();
        m_rd_q.delete();
        {m_nack, m_cmd_ovf, m_rd_ovf, m_rd_unf, m_irq_en} = '0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge apb_clk);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(negedge apb_clk);
        penable = 1;
        @(negedge apb_clk);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge apb_clk);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge apb_clk);
        penable = 1;
        #1;
        d = prdata;
        e = pslverr;
        @(negedge apb_clk);
        psel = 0; penable = 0;
    endtask

    task automatic do_reset();
        @(negedge apb_clk);
        apb_rstn = 0;
        repeat (3) @(negedge apb_clk);
        apb_rstn = 1;
        model_clear();
    endtask

    // Behaves as the I2C core for one transaction: waits for a command,
    // stalls randomly, accepts it, returns read data if needed, then done.
    task automatic serve_one(input logic a, input logic [RD_W-1:0] rd, output logic [FW-1:0] f);
        int n = 0;
        f = '0;
        while (!wvalid && n < 200) begin
            @(negedge apb_clk);
            n++;
        end
        if (!wvalid) begin
            check_val("wvalid_timeout", 32'(wvalid), 32'd1);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge apb_clk);
        check_val("wvalid_held", 32'(wvalid), 32'd1);
        f = {rh_wl, bit_ctrl, addr, wdata};
        wready = 1;
        @(negedge apb_clk);
        wready = 0;
        check_val("wvalid_drop", 32'(wvalid), 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge apb_clk);
        if (f[FW-1]) begin
            rdata = rd; rvalid = 1;
            @(negedge apb_clk);
            rvalid = 0;
        end
        ack = a; done = 1;
        @(negedge apb_clk);
        done = 0; ack = 0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, wd, cw, w1c;
        logic        e, a;
        logic [FW-1:0] f, ex;
        int k, nrd, n;

        do_reset();
        // ---- reset state ----
        check_val("rst_wvalid", 32'(wvalid), 0);
        check_val("rst_irq", 32'(irq), 0);
        check_val("rst_cmdout", 32'({rh_wl, bit_ctrl, addr, wdata}), 0);
        check_val("rst_prdata", prdata, 0);
        check_val("rst_pslverr", 32'(pslverr), 0);
        check_val("rst_pready", 32'(pready), 1);
        apb_read(A_STAT, d, e);
        check_val("rst_status", d, 32'h0000_000A);
        apb_read(A_CTRL, d, e);
        check_val("rst_ctrl", d, 0);

        // ---- write command, issue timing and payload ----
        apb_write(A_CTRL, 32'h1);
        apb_write(A_WDATA, 32'hA5);
        apb_write(A_CMD, 32'h4000_0010);
        check_val("t1_wvalid_n1", 32'(wvalid), 0);
        @(negedge apb_clk);
        check_val("t1_wvalid_n2", 32'(wvalid), 1);
        check_val("t1_fields", 32'({rh_wl, bit_ctrl, addr, wdata}), 32'({1'b0, 1'b1, 16'h0010, 8'hA5}));
        repeat (2) @(negedge apb_clk);
        check_val("t1_held", 32'({wvalid, rh_wl, bit_ctrl, addr, wdata}), 32'({1'b1, 1'b0, 1'b1, 16'h0010, 8'hA5}));
        wready = 1;
        @(negedge apb_clk);
        wready = 0;
        check_val("t1_wvalid_off", 32'(wvalid), 0);
        done = 1;
        @(negedge apb_clk);
        done = 0;
        apb_read(A_STAT, d, e);
        check_val("t1_status", d, 32'h0000_000A);

        // ---- read command with interrupt ----
        apb_write(A_CTRL, 32'h3);
        apb_write(A_CMD, 32'h8000_0022);
        serve_one(1'b0, 8'h3C, f);
        check_val("t2_fields", 32'(f), 32'({1'b1, 1'b0, 16'h0022, 8'hA5}));
        @(negedge apb_clk);
        check_val("t2_irq_on", 32'(irq), 1);
        apb_read(A_RDAT, d, e);
        check_val("t2_rdata", d, 32'h3C);
        apb_read(A_STAT, d, e);
        check_val("t2_status", d, 32'h0000_000A);
        check_val("t2_irq_off", 32'(irq), 0);

        // ---- halt on NACK ----
        apb_write(A_CTRL, 32'h4);
        apb_write(A_WDATA, 32'h11);
        apb_write(A_CMD, 32'h0000_0101);
        apb_write(A_WDATA, 32'h22);
        apb_write(A_CMD, 32'h4000_0202);
        apb_write(A_CTRL, 32'h5);
        serve_one(1'b1, 8'h00, f);
        check_val("t4_first", 32'(f), 32'({1'b0, 1'b0, 16'h0101, 8'h11}));
        repeat (8) @(negedge apb_clk);
        check_val("t4_halted", 32'(wvalid), 0);
        apb_read(A_STAT, d, e);
        check_val("t4_status", d, 32'h0000_0108);
        apb_write(A_STAT, 32'h100);
        serve_one(1'b0, 8'h00, f);
        check_val("t4_second", 32'(f), 32'({1'b0, 1'b1, 16'h0202, 8'h22}));
        apb_read(A_STAT, d, e);
        check_val("t4_status2", d, 32'h0000_000A);

        // ---- underflow and unmapped access ----
        apb_read(A_RDAT, d, e);
        check_val("t5_unf_data", d, 0);
        apb_read(A_STAT, d, e);
        check_val("t5_status", d, 32'h0000_080A);
        check_val("t5_ok_err", 32'(e), 0);
        apb_read(BASE + 32'h14, d, e);
        check_val("t5_slverr", 32'(e), 1);
        apb_write(A_STAT, 32'h800);
        apb_read(A_STAT, d, e);
        check_val("t5_unf_clr", d, 32'h0000_000A);

        // ---- flush ----
        apb_write(A_CTRL, 32'h0);
        apb_write(A_CMD, 32'h0000_0001);
        apb_write(A_CMD, 32'h0000_0002);
        apb_read(A_STAT, d, e);
        check_val("fl_before", d, 32'h0000_0008);
        apb_write(A_CTRL, 32'h8);
        apb_read(A_STAT, d, e);
        check_val("fl_after", d, 32'h0000_000A);
        apb_read(A_CTRL, d, e);
        check_val("fl_ctrl_rd", d, 0);

        // ---- reset while a command is in ISSUE ----
        apb_write(A_CTRL, 32'h1);
        apb_write(A_CMD, 32'h4000_1234);
        apb_write(A_CMD, 32'h0000_5678);
        n = 0;
        while (!wvalid && n < 50) begin
            @(negedge apb_clk);
            n++;
        end
        check_val("t6_in_issue", 32'(wvalid), 1);
        apb_rstn = 0;
        @(negedge apb_clk);
        check_val("t6_wvalid_drop", 32'({wvalid, addr}), 0);
        apb_rstn = 1;
        apb_read(A_STAT, d, e);
        check_val("t6_status", d, 32'h0000_000A);
        apb_write(A_CTRL, 32'h2);
        rdata = 8'h55; rvalid = 1; done = 1; ack = 1;
        @(negedge apb_clk);
        rvalid = 0; done = 0; ack = 0;
        @(negedge apb_clk);
        check_val("t6_irq", 32'(irq), 0);
        apb_read(A_STAT, d, e);
        check_val("t6_stray", d, 32'h0000_000A);

        // ---- randomized rounds against the reference model ----
        do_reset();
        for (int r = 0; r < 8; r++) begin
            m_irq_en = 1'($urandom_range(0, 1));
            apb_write(A_CTRL, {30'b0, m_irq_en, 1'b0});
            k = (r == 0) ? CMD_DEPTH + 1 : int'($urandom_range(1, CMD_DEPTH + 2));
            for (int i = 0; i < k; i++) begin
                wd = $urandom;
                cw = $urandom;
                apb_write(A_WDATA, wd);
                apb_write(A_CMD, cw);
                ex = {cw[31], cw[30], cw[15:0], wd[WR_W-1:0]};
                if (m_cmd_q.size() < CMD_DEPTH) m_cmd_q.push_back(ex);
                else m_cmd_ovf = 1;
            end
            apb_read(A_STAT, d, e);
            check_val("rnd_stat_fill", d, exp_status());
            w1c = (r == 0) ? 32'h200 : ($urandom & 32'h0000_0F00);
            apb_write(A_STAT, w1c);
            m_nack    &= ~w1c[8];
            m_cmd_ovf &= ~w1c[9];
            m_rd_ovf  &= ~w1c[10];
            m_rd_unf  &= ~w1c[11];
            apb_read(A_STAT, d, e);
            check_val("rnd_stat_w1c", d, exp_status());
            apb_write(A_CTRL, {30'b0, m_irq_en, 1'b1});
            while (m_cmd_q.size() > 0) begin
                a = ($urandom_range(0, 3) == 0);
                serve_one(a, RD_W'($urandom), f);
                ex = m_cmd_q.pop_front();
                check_val("rnd_cmd", 32'(f), 32'(ex));
                if (ex[FW-1]) begin
                    if (m_rd_q.size() < RD_DEPTH) m_rd_q.push_back(rdata);
                    else m_rd_ovf = 1;
                end
                if (a) m_nack = 1;
            end
            @(negedge apb_clk);
            check_val("rnd_irq", 32'(irq), 32'(exp_irq()));
            apb_read(A_STAT, d, e);
            check_val("rnd_stat_drain", d, exp_status());
            nrd = $urandom_range(0, m_rd_q.size() + 1);
            for (int i = 0; i < nrd; i++) begin
                apb_read(A_RDAT, d, e);
                if (m_rd_q.size() > 0) check_val("rnd_rdata", d, 32'(m_rd_q.pop_front()));
                else begin
                    m_rd_unf = 1;
                    check_val("rnd_rdata_unf", d, 0);
                end
            end
            apb_read(A_STAT, d, e);
            check_val("rnd_stat_end", d, exp_status());
            check_val("rnd_irq_end", 32'(irq), 32'(exp_irq()));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_i2c_master_ctrl.md
# apb_i2c_master_ctrl

APB3 slave that queues I2C transactions and sequences them into the team's existing I2C master core. Replaces the single-register, one-shot bridge with memory-mapped control/status registers, a parametrised command FIFO, a read-data FIFO, sticky error flags and an interrupt. The block sits between the APB interconnect and `i2c_master_module`, whose command/response ports it drives through the `m_i2c_*` ports.

## Interface
- `BASE_ADDR`, 32'h43C0_0000: APB base address; registers at BASE+0x00..0x10, word aligned.
- `APB_ABIT`, 32: PADDR width.
- `CMD_DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `RD_DEPTH`, 4: read FIFO entries, power of two, ≥2.
- `WR_BITS`, 1: write payload bytes, 1..4.
- `RD_BITS`, 1: read payload bytes, 1..4.
- `apb_clk` in 1: single clock.
- `apb_rstn` in 1: reset, synchronous, active-low.
- `i_apb_psel`, `i_apb_penable`, `i_apb_pwrite` in 1: APB control.
- `i_apb_paddr` in APB_ABIT: address.
- `i_apb_pwdata` in 32: write data.
- `o_apb_prdata` out 32: read data.
- `o_apb_pready` out 1: tied 1; zero-wait.
- `o_apb_pslverr` out 1: 1 on an access to an unmapped offset.
- `o_irq` out 1: level interrupt.
- `m_i2c_wvalid` out 1: command valid to the core.
- `m_i2c_wready` in 1: core accepts the command.
- `m_i2c_bit_ctrl` out 1: 1 = 16-bit word address.
- `m_i2c_rh_wl` out 1: 1 = read.
- `m_i2c_addr` out 16: word address.
- `m_i2c_wdata` out WR_BITS*8: write payload.
- `m_i2c_rdata` in RD_BITS*8: read payload.
- `m_i2c_rvalid` in 1: read payload valid, one-cycle pulse.
- `m_i2c_done` in 1: transaction complete, one-cycle pulse.
- `m_i2c_ack` in 1: qualified by done; 1 = slave NACK.

## Operation
- Register map:
  - CTRL 0x00 RW: [0] enable, [1] irq_en, [2] halt_on_nack, [3] flush (write-1, self-clearing, reads 0).
  - WDATA 0x04 RW: staging payload, low WR_BITS*8 bits.
  - CMD 0x08 WO: [31] rh_wl, [30] bit_ctrl, [15:0] addr. A write pushes {rh_wl, bit_ctrl, addr, WDATA}.
  - STATUS 0x0C: [0] busy, [1] cmd_empty, [2] cmd_full, [3] rd_empty, [4] rd_full, [8] nack, [9] cmd_ovf, [10] rd_ovf, [11] rd_unf. Bits [11:8] are sticky and W1C.
  - RDATA 0x10 RO: head of the read FIFO, zero-extended; a read pops the FIFO.
- APB access qualifier is psel & penable. `o_apb_prdata` is combinational during that qualifier and 0 otherwise.
- CMD write with the FIFO full: entry dropped, cmd_ovf set.
- RDATA read with the FIFO empty: returns 0, rd_unf set.
- m_i2c_rvalid with the read FIFO full: payload dropped, rd_ovf set.
- FSM states:
  - IDLE: go to ISSUE when enable & !cmd_empty & !(halt_on_nack & nack). This pops the command FIFO and registers all m_i2c_* command outputs.
  - ISSUE: m_i2c_wvalid=1; go to WAIT on m_i2c_wready.
  - WAIT: on m_i2c_done, set nack if m_i2c_ack; go to IDLE.
- busy = (state≠IDLE).
- Clearing enable does not abort an in-flight transaction; the block stops at the next IDLE.
- flush empties both FIFOs in the cycle after the write and does not affect the FSM. A same-cycle push and flush: flush wins.
- o_irq = irq_en & (!rd_empty | nack | cmd_ovf | rd_ovf).

## Timing
- Reset values:
  - All registers, FIFOs and sticky bits 0; FSM in IDLE.
  - Outputs: m_i2c_* = 0, o_irq = 0, o_apb_prdata = 0, o_apb_pslverr = 0.
- Reset mid-transaction: m_i2c_wvalid drops the next cycle. Responses from the core arriving after reset are ignored.
- CMD write with the access phase at cycle N: cmd_empty=0 at N+1; FSM enters ISSUE at N+2 (m_i2c_wvalid high).
- m_i2c_wvalid is held, with stable payload, until m_i2c_wready is sampled high. It deasserts the following cycle.
- rvalid → rd_empty=0 the next cycle.
- The first done-to-next-wvalid gap is 2 cycles when the command FIFO is non-empty.
- Simultaneous FIFO push and pop: both occur; the count is unchanged. This also holds when the FIFO is full and the pop frees the slot, so no overflow is flagged.
- Simultaneous hardware set and W1C on the same sticky bit: the set wins.

## Structure
- Package `apb_i2c_pkg`:
  - register offsets and CTRL/STATUS bit indices;
  - FSM state encoding (IDLE/ISSUE/WAIT);
  - command-entry field widths.
- Sub-module `i2c_sync_fifo` (params WIDTH, DEPTH): push/pop/flush, full/empty flags, first-word-fall-through, single clock with synchronous active-low reset. Instantiated twice.

## Test plan
- Enable, WDATA=0xA5, CMD=0x4000_0010 → m_i2c_wvalid rises 2 cycles after the CMD access phase with addr=0x0010, bit_ctrl=1, rh_wl=0, wdata=0xA5. Core done with ack=0 → STATUS busy=0, nack=0.
- Read CMD, core returns rdata=0x3C → o_irq=1 with irq_en set. RDATA read returns 0x3C; rd_empty=1 afterwards and o_irq falls.
- Push CMD_DEPTH+1 commands while enable=0 → cmd_full=1 and cmd_ovf=1. W1C 0x200 clears cmd_ovf. Setting enable drains exactly CMD_DEPTH transactions in FIFO order.
- halt_on_nack=1, two queued commands, first done with ack=1 → nack set, second not issued. W1C 0x100 → second issues.
- RDATA read when empty → 0 and rd_unf=1. Access to BASE+0x14 → o_apb_pslverr=1.
- Assert apb_rstn low while in ISSUE → next cycle m_i2c_wvalid=0, all STATUS bits reset, FIFOs empty.
